ob_cn_sched: RTL and testbench

// Front-end scheduler for the conditional (CN) table and the order-book engine.

---
 rtl/ob_pkg.sv | 43 ++++
 rtl/ob_cn_sched_arb.sv | 50 +++++
 rtl/ob_cn_sched.sv | 192 +++++++++++++++++++
 tb/tb_ob_cn_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared types for the order-book front end: command format, CN response codes, scheduler FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ob_pkg;

  typedef logic [7:0] uid_t;

  typedef enum logic [1:0] {
    OP_NEW    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_MODIFY = 2'd2,
    OP_COND   = 2'd3
  } cmd_op_t;

  typedef struct packed {
    cmd_op_t     op;
    uid_t        uid;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef enum logic [1:0] {
    CN_RSP_ACCEPT      = 2'd0,
    CN_RSP_REJECT_FULL = 2'd1,
    CN_RSP_CANCEL_HIT  = 2'd2
  } cn_rsp_t;

  typedef enum logic {
    ST_DISPATCH = 1'b0,
    ST_RESOLVE  = 1'b1
  } cn_sched_state_t;

  // Conditional commands are parked in the CN table until they mature.
  function automatic logic is_cn_cmd(input cmd_t c);
    return c.op == OP_COND;
  endfunction

  // Cancels probe the CN table before they are allowed to reach the engine.
  function automatic logic is_cancel_cmd(input cmd_t c);
    return c.op == OP_CANCEL;
  endfunction

endpackage

// File: rtl/ob_cn_sched_arb.sv
// Two-source engine arbiter: matured CN commands win, but at most MAX_MTR_BURST in a row while ingress waits.
// Latency: grant is combinational from load_en/requests; burst counter updates on the next clk.
// Backpressure: grants only when load_en (engine slot free) is high; no grant otherwise.
// Ports: load_en (slot loadable), mtr_vld (matured request), ing_pend (engine-bound ingress request),
//        mtr_grant / ing_grant (one-hot or both low).
module ob_cn_sched_arb
  import ob_pkg::*;
#(
  parameter int unsigned MAX_MTR_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic mtr_vld,
  input  logic ing_pend,
  output logic mtr_grant,
  output logic ing_grant
);

  localparam int unsigned BURST_W = $clog2(MAX_MTR_BURST + 1);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_MTR_BURST);

  logic [BURST_W-1:0] burst_cnt_q;
  logic [BURST_W-1:0] burst_cnt_d;
  logic               at_limit;

  assign at_limit = (burst_cnt_q == MAX_B);

  always_comb begin
    mtr_grant   = load_en & mtr_vld & ~(ing_pend & at_limit);
    ing_grant   = load_en & ing_pend & ~mtr_grant;
    burst_cnt_d = burst_cnt_q;
    // The count only measures how long the current ingress command has been
    // passed over; it is meaningless once nothing engine-bound is waiting.
    if (ing_grant || !ing_pend) begin
      burst_cnt_d = '0;
    end else if (mtr_grant && !at_limit) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/ob_cn_sched.sv
// Front-end scheduler: routes ingress commands to the CN table or the engine and merges matured CN traffic.
// Latency: ENG cmd T->T+2 on eng_vld_r; CN rsp T+2; cancel probe T+1, rsp (hit) or engine (miss) at T+3.
// Backpressure: one-entry ingress slot; in_accept drops while in_r waits on rsp slot or engine grant.
// Ports: in_* ingress; cn_cmd_* CN allocate; cn_mtr_* matured source; cn_cancel_* CN probe;
//        eng_* registered engine issue (held while eng_accept low); rsp_* registered CN-path response.
module ob_cn_sched
  import ob_pkg::*;
#(
  parameter int unsigned MAX_MTR_BURST = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_vld,
  input  cmd_t    in_cmd,
  output logic    in_accept,
  output logic    cn_cmd_vld,
  output cmd_t    cn_cmd,
  input  logic    cn_full_r,
  input  logic    cn_mtr_vld_r,
  input  cmd_t    cn_mtr_r,
  output logic    cn_mtr_accept,
  output logic    cn_cancel,
  output uid_t    cn_cancel_uid,
  input  logic    cn_cancel_hit_w,
  output logic    eng_vld_r,
  output cmd_t    eng_cmd_r,
  input  logic    eng_accept,
  output logic    rsp_vld_r,
  output uid_t    rsp_uid_r,
  output cn_rsp_t rsp_status_r,
  input  logic    rsp_accept
);

  cn_sched_state_t state_q, state_d;
  logic            in_vld_q, in_vld_d;
  cmd_t            in_q, in_d;
  logic            hit_q, hit_d;
  logic            rsp_vld_q, rsp_vld_d;
  uid_t            rsp_uid_q, rsp_uid_d;
  cn_rsp_t         rsp_status_q, rsp_status_d;
  logic            eng_vld_q, eng_vld_d;
  cmd_t            eng_cmd_q, eng_cmd_d;

  logic in_is_cn;
  logic in_is_cancel;
  logic rsp_free;
  logic eng_ld;
  logic ing_pend;
  logic mtr_grant;
  logic ing_grant;
  logic consume;
  logic rsp_load;
  cn_rsp_t rsp_code;

  assign in_is_cn     = is_cn_cmd(in_q);
  assign in_is_cancel = is_cancel_cmd(in_q);
  assign rsp_free     = ~rsp_vld_q | rsp_accept;
  // Gated by rst so no grant or pulse escapes while state is being cleared.
  assign eng_ld       = (~eng_vld_q | eng_accept) & ~rst;
  // A missed cancel waiting in RESOLVE competes for the engine like any ENG command.
  assign ing_pend     = in_vld_q &
                        (((state_q == ST_DISPATCH) & ~in_is_cn & ~in_is_cancel) |
                         ((state_q == ST_RESOLVE) & ~hit_q));

  ob_cn_sched_arb #(
    .MAX_MTR_BURST(MAX_MTR_BURST)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .load_en  (eng_ld),
    .mtr_vld  (cn_mtr_vld_r),
    .ing_pend (ing_pend),
    .mtr_grant(mtr_grant),
    .ing_grant(ing_grant)
  );

  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    consume    = 1'b0;
    rsp_load   = 1'b0;
    rsp_code   = CN_RSP_ACCEPT;
    cn_cmd_vld = 1'b0;
    cn_cancel  = 1'b0;

    if (!rst && in_vld_q) begin
      case (state_q)
        ST_DISPATCH: begin
          if (in_is_cn) begin
            if (rsp_free) begin
              rsp_load   = 1'b1;
              consume    = 1'b1;
              cn_cmd_vld = ~cn_full_r;
              rsp_code   = cn_full_r ? CN_RSP_REJECT_FULL : CN_RSP_ACCEPT;
            end
          end else if (in_is_cancel) begin
            // Probe only once the response slot is free so a hit never has to
            // be remembered across an arbitrary stall before it can report.
            if (rsp_free) begin
              cn_cancel = 1'b1;
              hit_d     = cn_cancel_hit_w;
              state_d   = ST_RESOLVE;
            end
          end else if (ing_grant) begin
            consume = 1'b1;
          end
        end
        ST_RESOLVE: begin
          if (hit_q) begin
            if (rsp_free) begin
              rsp_load = 1'b1;
              rsp_code = CN_RSP_CANCEL_HIT;
              consume  = 1'b1;
              state_d  = ST_DISPATCH;
            end
          end else if (ing_grant) begin
            consume = 1'b1;
            state_d = ST_DISPATCH;
          end
        end
        default: state_d = ST_DISPATCH;
      endcase
    end

    in_accept = in_vld & (~in_vld_q | consume) & ~rst;

    in_vld_d = in_vld_q;
    in_d     = in_q;
    if (in_accept) begin
      in_vld_d = 1'b1;
      in_d     = in_cmd;
    end else if (consume) begin
      in_vld_d = 1'b0;
    end

    rsp_vld_d    = rsp_vld_q;
    rsp_uid_d    = rsp_uid_q;
    rsp_status_d = rsp_status_q;
    if (rsp_load) begin
      rsp_vld_d    = 1'b1;
      rsp_uid_d    = in_q.uid;
      rsp_status_d = rsp_code;
    end else if (rsp_accept) begin
      rsp_vld_d = 1'b0;
    end

    eng_vld_d = eng_vld_q;
    eng_cmd_d = eng_cmd_q;
    if (eng_ld) begin
      eng_vld_d = mtr_grant | ing_grant;
      if (mtr_grant) begin
        eng_cmd_d = cn_mtr_r;
      end else if (ing_grant) begin
        eng_cmd_d = in_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_DISPATCH;
      in_vld_q     <= 1'b0;
      in_q         <= '0;
      hit_q        <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_uid_q    <= '0;
      rsp_status_q <= CN_RSP_ACCEPT;
      eng_vld_q    <= 1'b0;
      eng_cmd_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_vld_q     <= in_vld_d;
      in_q         <= in_d;
      hit_q        <= hit_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_uid_q    <= rsp_uid_d;
      rsp_status_q <= rsp_status_d;
      eng_vld_q    <= eng_vld_d;
      eng_cmd_q    <= eng_cmd_d;
    end
  end

  assign cn_cmd        = in_q;
  assign cn_cancel_uid = in_q.uid;
  assign cn_mtr_accept = mtr_grant;
  assign eng_vld_r     = eng_vld_q;
  assign eng_cmd_r     = eng_cmd_q;
  assign rsp_vld_r     = rsp_vld_q;
  assign rsp_uid_r     = rsp_uid_q;
  assign rsp_status_r  = rsp_status_q;

endmodule

// File: tb/tb_ob_cn_sched.sv
`timescale 1ns/1ps
module tb_ob_cn_sched;
  import ob_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_vld;
  cmd_t    in_cmd;
  logic    in_accept;
  logic    cn_cmd_vld;
  cmd_t    cn_cmd;
  logic    cn_full_r;
  logic    cn_mtr_vld_r;
  cmd_t    cn_mtr_r;
  logic    cn_mtr_accept;
  logic    cn_cancel;
  uid_t    cn_cancel_uid;
  logic    cn_cancel_hit_w;
  logic    eng_vld_r;
  cmd_t    eng_cmd_r;
  logic    eng_accept;
  logic    rsp_vld_r;
  uid_t    rsp_uid_r;
  cn_rsp_t rsp_status_r;
  logic    rsp_accept;

  ob_cn_sched #(.MAX_MTR_BURST(2)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_cmd(in_cmd), .in_accept(in_accept),
    .cn_cmd_vld(cn_cmd_vld), .cn_cmd(cn_cmd), .cn_full_r(cn_full_r),
    .cn_mtr_vld_r(cn_mtr_vld_r), .cn_mtr_r(cn_mtr_r), .cn_mtr_accept(cn_mtr_accept),
    .cn_cancel(cn_cancel), .cn_cancel_uid(cn_cancel_uid), .cn_cancel_hit_w(cn_cancel_hit_w),
    .eng_vld_r(eng_vld_r), .eng_cmd_r(eng_cmd_r), .eng_accept(eng_accept),
    .rsp_vld_r(rsp_vld_r), .rsp_uid_r(rsp_uid_r), .rsp_status_r(rsp_status_r),
    .rsp_accept(rsp_accept)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { cmd_t cmd; int cyc; } cmd_exp_t;
  typedef struct { uid_t uid; cn_rsp_t st; int cyc; } rsp_exp_t;

  cmd_exp_t eng_q[$];
  cmd_exp_t cn_q[$];
  cmd_exp_t cxl_q[$];
  rsp_exp_t rsp_q[$];

  function automatic cmd_t mk(input cmd_op_t op, input uid_t uid);
    cmd_t c;
    c.op    = op;
    c.uid   = uid;
    c.price = {uid, 8'h55};
    c.qty   = {8'h00, uid} + 16'd1;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected output %0h, nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_eng(input cmd_t c, input int at);
    cmd_exp_t e;
    e.cmd = c; e.cyc = at;
    eng_q.push_back(e);
  endtask

  task automatic push_cn(input cmd_t c, input int at);
    cmd_exp_t e;
    e.cmd = c; e.cyc = at;
    cn_q.push_back(e);
  endtask

  task automatic push_cxl(input cmd_t c, input int at);
    cmd_exp_t e;
    e.cmd = c; e.cyc = at;
    cxl_q.push_back(e);
  endtask

  task automatic push_rsp(input uid_t u, input cn_rsp_t st, input int at);
    rsp_exp_t r;
    r.uid = u; r.st = st; r.cyc = at;
    rsp_q.push_back(r);
  endtask

  // Drive one ingress command until it is taken; t is the cycle of in_accept.
  task automatic send(input cmd_t c, output int t);
    int n;
    n = 0;
    t = -1;
    in_vld = 1'b1;
    in_cmd = c;
    while (t < 0 && n < 100) begin
      @(negedge clk);
      if (in_accept) t = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout: uid %0h never accepted", c.uid);
    end
  endtask

  task automatic wait_eng_vld();
    int n;
    n = 0;
    while (!eng_vld_r && n < 20) begin
      tick();
      n++;
    end
    chk("wait_eng_vld", eng_vld_r, 1'b1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer or pulse.
  cmd_exp_t me;
  rsp_exp_t mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_vld_r && eng_accept) begin
        if (eng_q.size() == 0) unexpected("eng_issue", 64'(eng_cmd_r));
        else begin
          me = eng_q.pop_front();
          chk("eng_cmd", 64'(eng_cmd_r), 64'(me.cmd));
          if (me.cyc >= 0) chk("eng_cyc", cyc, me.cyc);
        end
      end
      if (rsp_vld_r && rsp_accept) begin
        if (rsp_q.size() == 0) unexpected("rsp", {rsp_status_r, rsp_uid_r});
        else begin
          mr = rsp_q.pop_front();
          chk("rsp_uid", rsp_uid_r, mr.uid);
          chk("rsp_status", rsp_status_r, mr.st);
          if (mr.cyc >= 0) chk("rsp_cyc", cyc, mr.cyc);
        end
      end
      if (cn_cmd_vld) begin
        if (cn_q.size() == 0) unexpected("cn_alloc", 64'(cn_cmd));
        else begin
          me = cn_q.pop_front();
          chk("cn_cmd", 64'(cn_cmd), 64'(me.cmd));
          if (me.cyc >= 0) chk("cn_cyc", cyc, me.cyc);
        end
      end
      if (cn_cancel) begin
        if (cxl_q.size() == 0) unexpected("cn_cancel", cn_cancel_uid);
        else begin
          me = cxl_q.pop_front();
          chk("cancel_uid", cn_cancel_uid, me.cmd.uid);
          if (me.cyc >= 0) chk("cancel_cyc", cyc, me.cyc);
        end
      end
    end
  end

  // Matured-command source: offers M<idx> while idx < mtr_total, advances on accept.
  int   mtr_idx   = 0;
  int   mtr_total = 0;
  logic mtr_took;
  initial begin
    cn_mtr_vld_r = 1'b0;
    cn_mtr_r     = mk(OP_NEW, 8'h80);
    forever begin
      @(negedge clk);
      mtr_took = cn_mtr_accept;
      @(posedge clk);
      #1;
      if (mtr_took) mtr_idx++;
      cn_mtr_vld_r = (mtr_idx < mtr_total);
      cn_mtr_r     = mk(OP_NEW, uid_t'(8'h80 + mtr_idx));
    end
  end

  initial begin
    int t;
    rst             = 1'b1;
    in_vld          = 1'b0;
    in_cmd          = '0;
    cn_full_r       = 1'b0;
    cn_cancel_hit_w = 1'b0;
    eng_accept      = 1'b1;
    rsp_accept      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {in_accept, cn_cmd_vld, cn_cancel, cn_mtr_accept, eng_vld_r, rsp_vld_r}, 6'b0);
    chk("reset_burst", dut.u_arb.burst_cnt_q, 0);
    tick();

    // Plain engine command: eng_vld_r at T+2.
    send(mk(OP_NEW, 8'h30), t);
    push_eng(mk(OP_NEW, 8'h30), t + 2);
    repeat (6) tick();

    // 1. CN allocate, table not full.
    send(mk(OP_COND, 8'h12), t);
    push_cn(mk(OP_COND, 8'h12), t + 1);
    push_rsp(8'h12, CN_RSP_ACCEPT, t + 2);
    repeat (6) tick();

    // 2. CN allocate, table full.
    cn_full_r = 1'b1;
    send(mk(OP_COND, 8'h13), t);
    push_rsp(8'h13, CN_RSP_REJECT_FULL, t + 2);
    repeat (6) tick();
    cn_full_r = 1'b0;

    // Response backpressure: second CN command waits for the rsp slot.
    rsp_accept = 1'b0;
    send(mk(OP_COND, 8'h40), t);
    push_cn(mk(OP_COND, 8'h40), t + 1);
    push_rsp(8'h40, CN_RSP_ACCEPT, -1);
    send(mk(OP_COND, 8'h41), t);
    push_cn(mk(OP_COND, 8'h41), -1);
    push_rsp(8'h41, CN_RSP_ACCEPT, -1);
    repeat (3) tick();
    @(negedge clk);
    chk("stall_cn_vld", cn_cmd_vld, 1'b0);
    chk("stall_rsp_uid", rsp_uid_r, 8'h40);
    tick();
    rsp_accept = 1'b1;
    repeat (6) tick();

    // 3. Cancel hit.
    cn_cancel_hit_w = 1'b1;
    send(mk(OP_CANCEL, 8'h05), t);
    push_cxl(mk(OP_CANCEL, 8'h05), t + 1);
    push_rsp(8'h05, CN_RSP_CANCEL_HIT, t + 3);
    repeat (6) tick();

    // 4. Cancel miss goes to the engine.
    cn_cancel_hit_w = 1'b0;
    send(mk(OP_CANCEL, 8'h06), t);
    push_cxl(mk(OP_CANCEL, 8'h06), t + 1);
    push_eng(mk(OP_CANCEL, 8'h06), t + 3);
    repeat (6) tick();

    // 5. Burst limit 2: M0 parked, then M1,M2,I1,M3,M4,I2,M5.
    eng_accept = 1'b0;
    mtr_total  = 6;
    push_eng(mk(OP_NEW, 8'h80), -1);
    push_eng(mk(OP_NEW, 8'h81), -1);
    push_eng(mk(OP_NEW, 8'h82), -1);
    push_eng(mk(OP_MODIFY, 8'h21), -1);
    push_eng(mk(OP_NEW, 8'h83), -1);
    push_eng(mk(OP_NEW, 8'h84), -1);
    push_eng(mk(OP_MODIFY, 8'h22), -1);
    push_eng(mk(OP_NEW, 8'h85), -1);
    wait_eng_vld();
    repeat (2) tick();
    send(mk(OP_MODIFY, 8'h21), t);
    eng_accept = 1'b1;
    send(mk(OP_MODIFY, 8'h22), t);
    repeat (12) tick();

    // 6. Stall with M7 in the slot and I3 waiting, then reset.
    eng_accept = 1'b0;
    mtr_total  = 9;
    push_eng(mk(OP_NEW, 8'h86), -1);
    wait_eng_vld();
    send(mk(OP_NEW, 8'h23), t);
    eng_accept = 1'b1;
    tick();
    eng_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_eng_vld", eng_vld_r, 1'b1);
      chk("stall_eng_cmd", 64'(eng_cmd_r), 64'(mk(OP_NEW, 8'h87)));
      chk("stall_mtr_acc", cn_mtr_accept, 1'b0);
      tick();
    end
    chk("pre_rst_burst", dut.u_arb.burst_cnt_q, 1);
    rst       = 1'b1;
    mtr_total = mtr_idx;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {in_accept, cn_cmd_vld, cn_cancel, cn_mtr_accept, eng_vld_r, rsp_vld_r}, 6'b0);
    chk("post_rst_burst", dut.u_arb.burst_cnt_q, 0);
    tick();
    eng_accept = 1'b1;
    repeat (10) tick();

    chk("eng_q_left", eng_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    chk("cn_q_left", cn_q.size(), 0);
    chk("cxl_q_left", cxl_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
